// File: rtl/pointer_bank_pkg.sv
// Shared opcode encoding, FSM states and parameter defaults for the pointer bank.
package pointer_bank_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_NUM_PTR = 4;
    localparam int DEF_STEP_W  = 4;

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_LOAD      = 3'd1,
        OP_INC       = 3'd2,
        OP_DEC       = 3'd3,
        OP_SET_BASE  = 3'd4,
        OP_SET_LIMIT = 3'd5,
        OP_CLR_WRAP  = 3'd6,
        OP_STREAM    = 3'd7
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/ptr_wrap_arith.sv
// Step-with-wrap arithmetic inside [base, limit]; one instance serves both command and stream paths.
module ptr_wrap_arith #(
    parameter int WIDTH  = 16,
    parameter int STEP_W = 4
) (
    input  logic [WIDTH-1:0]  ptr,
    input  logic [WIDTH-1:0]  base,
    input  logic [WIDTH-1:0]  limit,
    input  logic [STEP_W-1:0] step,
    input  logic              dec,
    output logic [WIDTH-1:0]  result,
    output logic              wrap
);

    localparam int EW = WIDTH + 1;
    localparam logic [EW-1:0] ONE = EW'(1);

    logic [EW-1:0] p, b, l, s, span, sum;

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        result = ptr;
        wrap   = 1'b0;
        p      = {1'b0, ptr};
        b      = {1'b0, base};
        l      = {1'b0, limit};
        s      = EW'(step);
        span   = l - b + ONE;
        sum    = p + s;

        if (step == '0) begin
            result = ptr;
        end else if ((base > limit) || (ptr < base) || (ptr > limit) || (s > span)) begin
            // Inconsistent window or oversized step: snap to base and flag it.
            result = base;
            wrap   = 1'b1;
        end else if (!dec) begin
            if (sum > l) begin
                result = WIDTH'(b + (sum - l - ONE));
                wrap   = 1'b1;
            end else begin
                result = WIDTH'(sum);
            end
        end else begin
            if (p < (b + s)) begin
                // limit - (base - (ptr - step)) + 1, reordered to stay non-negative.
                result = WIDTH'(l + ONE - b + p - s);
                wrap   = 1'b1;
            end else begin
                result = WIDTH'(p - s);
            end
        end
    end

endmodule

// File: rtl/pointer_bank.sv
// Bank of wrapping pointers with a command port, a combinational read port and a beat streamer.
module pointer_bank
    import pointer_bank_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_PTR = DEF_NUM_PTR,
    parameter int STEP_W  = DEF_STEP_W,
    localparam int SEL_W  = $clog2(NUM_PTR)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [SEL_W-1:0]  cmd_sel,
    input  logic [WIDTH-1:0]  cmd_data,
    input  logic [STEP_W-1:0] cmd_step,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [WIDTH-1:0]  rd_ptr,
    output logic              rd_wrap,
    output logic              stream_valid,
    input  logic              stream_ready,
    output logic [WIDTH-1:0]  stream_addr,
    output logic              stream_last
);

    logic [WIDTH-1:0]  ptr_q   [NUM_PTR];
    logic [WIDTH-1:0]  base_q  [NUM_PTR];
    logic [WIDTH-1:0]  limit_q [NUM_PTR];
    logic [NUM_PTR-1:0] wrap_q;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  ch_q, ch_d;
    logic [STEP_W-1:0] step_q, step_d;

    op_e               op;
    logic              cmd_fire, beat_fire;
    logic              ar_fire, ar_dec, ar_wrap;
    logic [SEL_W-1:0]  ar_ch;
    logic [STEP_W-1:0] ar_step;
    logic [WIDTH-1:0]  ar_result;

    assign op        = op_e'(cmd_op);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign beat_fire = stream_valid && stream_ready;

    assign rd_ptr  = ptr_q[rd_sel];
    assign rd_wrap = wrap_q[rd_sel];

    // The streamer owns the arithmetic while running; commands are blocked then.
    always_comb begin
        ar_ch   = cmd_sel;
        ar_step = cmd_step;
        ar_dec  = (op == OP_DEC);
        ar_fire = cmd_fire && ((op == OP_INC) || (op == OP_DEC));
        if (state_q == ST_RUN) begin
            ar_ch   = ch_q;
            ar_step = step_q;
            ar_dec  = 1'b0;
            ar_fire = beat_fire;
        end
    end

    ptr_wrap_arith #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_arith (
        .ptr    (ptr_q[ar_ch]),
        .base   (base_q[ar_ch]),
        .limit  (limit_q[ar_ch]),
        .step   (ar_step),
        .dec    (ar_dec),
        .result (ar_result),
        .wrap   (ar_wrap)
    );

    // NOTE: the per-channel arrays are a handful of flops with defined reset values, so they are reset like any register rather than treated as RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PTR; i++) begin
                ptr_q[i]   <= '0;
                base_q[i]  <= '0;
                limit_q[i] <= '1;
            end
            wrap_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values, independent of statement order.
            if (ar_fire) ptr_q[ar_ch] <= ar_result;
            if (cmd_fire) begin
                case (op)
                    OP_LOAD:      ptr_q[cmd_sel]   <= cmd_data;
                    OP_SET_BASE:  base_q[cmd_sel]  <= cmd_data;
                    OP_SET_LIMIT: limit_q[cmd_sel] <= cmd_data;
                    default: ;
                endcase
            end
            for (int i = 0; i < NUM_PTR; i++) begin
                if (ar_fire && ar_wrap && (ar_ch == SEL_W'(i)))
                    wrap_q[i] <= 1'b1;
                else if (cmd_fire && (op == OP_CLR_WRAP) && (cmd_sel == SEL_W'(i)))
                    wrap_q[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ch_q    <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ch_d         = ch_q;
        step_d       = step_q;
        cmd_ready    = 1'b0;
        stream_valid = 1'b0;
        stream_addr  = '0;
        stream_last  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && (op == OP_STREAM) && (cmd_data != '0)) begin
                    state_d = ST_RUN;
                    cnt_d   = cmd_data;
                    ch_d    = cmd_sel;
                    step_d  = cmd_step;
                end
            end
            ST_RUN: begin
                stream_valid = 1'b1;
                stream_addr  = ptr_q[ch_q];
                stream_last  = (cnt_q == WIDTH'(1));
                if (stream_ready) begin
                    cnt_d = cnt_q - WIDTH'(1);
                    if (cnt_q == WIDTH'(1)) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pointer_bank.sv
// Directed self-checking bench for pointer_bank: commands, wrap rules, streaming and mid-stream reset.
module tb_pointer_bank;
    import pointer_bank_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [1:0]  cmd_sel;
    logic [15:0] cmd_data;
    logic [3:0]  cmd_step;
    logic [1:0]  rd_sel;
    logic [15:0] rd_ptr;
    logic        rd_wrap;
    logic        stream_valid;
    logic        stream_ready;
    logic [15:0] stream_addr;
    logic        stream_last;

    int n_tests = 0;
    int n_fail  = 0;

    pointer_bank dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_sel      (cmd_sel),
        .cmd_data     (cmd_data),
        .cmd_step     (cmd_step),
        .rd_sel       (rd_sel),
        .rd_ptr       (rd_ptr),
        .rd_wrap      (rd_wrap),
        .stream_valid (stream_valid),
        .stream_ready (stream_ready),
        .stream_addr  (stream_addr),
        .stream_last  (stream_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one command; returns at the falling edge after the accepting clock edge.
    task automatic cmd(input logic [2:0] op, input logic [1:0] sel,
                       input logic [15:0] data, input logic [3:0] step);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_sel   = sel;
        cmd_data  = data;
        cmd_step  = step;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
    endtask

    task automatic rd_check(input string tag, input logic [1:0] sel,
                            input logic [15:0] exp_ptr, input logic exp_wrap);
        rd_sel = sel;
        #1;
        check({tag, ".ptr"}, 32'(rd_ptr), 32'(exp_ptr));
        check({tag, ".wrap"}, 32'(rd_wrap), 32'(exp_wrap));
    endtask

    task automatic stream_check(input string tag, input logic exp_valid,
                                input logic [15:0] exp_addr, input logic exp_last,
                                input logic exp_ready);
        check({tag, ".valid"}, 32'(stream_valid), 32'(exp_valid));
        check({tag, ".addr"}, 32'(stream_addr), 32'(exp_addr));
        check({tag, ".last"}, 32'(stream_last), 32'(exp_last));
        check({tag, ".cmd_ready"}, 32'(cmd_ready), 32'(exp_ready));
    endtask

    initial begin
        reset        = 1'b1;
        cmd_valid    = 1'b0;
        cmd_op       = OP_NOP;
        cmd_sel      = '0;
        cmd_data     = '0;
        cmd_step     = '0;
        rd_sel       = '0;
        stream_ready = 1'b0;

        // Reset state, during and after reset
        repeat (2) @(negedge clk);
        stream_check("rst_during", 1'b0, 16'h0, 1'b0, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        stream_check("rst_after", 1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) rd_check("rst_ch", 2'(i), 16'h0, 1'b0);

        // LOAD is visible on its own channel only
        cmd(OP_LOAD, 2'd1, 16'h1234, 4'd0);
        rd_check("load_ch1", 2'd1, 16'h1234, 1'b0);
        rd_check("load_ch0", 2'd0, 16'h0000, 1'b0);
        rd_check("load_ch2", 2'd2, 16'h0000, 1'b0);
        rd_check("load_ch3", 2'd3, 16'h0000, 1'b0);

        // Reset limit is 0xFFFF: 0xFFFE + 3 wraps to base 0 + 1
        cmd(OP_LOAD, 2'd3, 16'hFFFE, 4'd0);
        cmd(OP_INC, 2'd3, 16'h0, 4'd3);
        rd_check("full_wrap", 2'd3, 16'h0001, 1'b1);
        cmd(OP_CLR_WRAP, 2'd3, 16'h0, 4'd0);
        rd_check("full_clr", 2'd3, 16'h0001, 1'b0);

        // Window [0x10,0x1F] on ch0
        cmd(OP_SET_BASE, 2'd0, 16'h0010, 4'd0);
        cmd(OP_SET_LIMIT, 2'd0, 16'h001F, 4'd0);
        cmd(OP_LOAD, 2'd0, 16'h001E, 4'd0);
        rd_check("win_load", 2'd0, 16'h001E, 1'b0);
        cmd(OP_INC, 2'd0, 16'h0, 4'd3);
        rd_check("inc_wrap", 2'd0, 16'h0011, 1'b1);
        cmd(OP_CLR_WRAP, 2'd0, 16'h0, 4'd0);
        rd_check("inc_clr", 2'd0, 16'h0011, 1'b0);
        cmd(OP_DEC, 2'd0, 16'h0, 4'd4);
        rd_check("dec_wrap", 2'd0, 16'h001D, 1'b1);
        cmd(OP_DEC, 2'd0, 16'h0, 4'd0);
        rd_check("dec_step0", 2'd0, 16'h001D, 1'b1);
        cmd(OP_CLR_WRAP, 2'd0, 16'h0, 4'd0);
        cmd(OP_INC, 2'd0, 16'h0, 4'd0);
        rd_check("inc_step0", 2'd0, 16'h001D, 1'b0);
        cmd(OP_INC, 2'd0, 16'h0, 4'd2);
        rd_check("inc_to_limit", 2'd0, 16'h001F, 1'b0);
        cmd(OP_INC, 2'd0, 16'h0, 4'd1);
        rd_check("inc_limit_p1", 2'd0, 16'h0010, 1'b1);
        cmd(OP_CLR_WRAP, 2'd0, 16'h0, 4'd0);
        cmd(OP_DEC, 2'd0, 16'h0, 4'd1);
        rd_check("dec_base_m1", 2'd0, 16'h001F, 1'b1);
        cmd(OP_CLR_WRAP, 2'd0, 16'h0, 4'd0);
        cmd(OP_DEC, 2'd0, 16'h0, 4'd5);
        rd_check("dec_nowrap", 2'd0, 16'h001A, 1'b0);

        // Pointer outside the window snaps to base
        cmd(OP_LOAD, 2'd0, 16'h0005, 4'd0);
        cmd(OP_INC, 2'd0, 16'h0, 4'd1);
        rd_check("out_of_win", 2'd0, 16'h0010, 1'b1);

        // Step larger than the window snaps to base
        cmd(OP_SET_LIMIT, 2'd0, 16'h0012, 4'd0);
        cmd(OP_CLR_WRAP, 2'd0, 16'h0, 4'd0);
        cmd(OP_LOAD, 2'd0, 16'h0011, 4'd0);
        cmd(OP_INC, 2'd0, 16'h0, 4'd5);
        rd_check("big_step", 2'd0, 16'h0010, 1'b1);
        rd_check("big_step_ch1", 2'd1, 16'h1234, 1'b0);

        // Stream N=3 step 2 on ch2 with backpressure; a LOAD during RUN is ignored
        cmd(OP_LOAD, 2'd2, 16'h0100, 4'd0);
        cmd(OP_STREAM, 2'd2, 16'd3, 4'd2);
        stream_check("beat0", 1'b1, 16'h0100, 1'b0, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = OP_LOAD;
        cmd_sel   = 2'd2;
        cmd_data  = 16'hDEAD;
        @(negedge clk);
        stream_check("beat0_hold", 1'b1, 16'h0100, 1'b0, 1'b0);
        cmd_valid    = 1'b0;
        cmd_op       = OP_NOP;
        stream_ready = 1'b1;
        @(negedge clk);
        stream_check("beat1", 1'b1, 16'h0102, 1'b0, 1'b0);
        stream_ready = 1'b0;
        @(negedge clk);
        stream_check("beat1_hold", 1'b1, 16'h0102, 1'b0, 1'b0);
        stream_ready = 1'b1;
        @(negedge clk);
        stream_check("beat2", 1'b1, 16'h0104, 1'b1, 1'b0);
        stream_ready = 1'b0;
        @(negedge clk);
        stream_check("beat2_hold", 1'b1, 16'h0104, 1'b1, 1'b0);
        stream_ready = 1'b1;
        @(negedge clk);
        stream_ready = 1'b0;
        stream_check("stream_done", 1'b0, 16'h0000, 1'b0, 1'b1);
        rd_check("stream_ptr", 2'd2, 16'h0106, 1'b0);

        // Reset after the first beat of an N=5 stream
        cmd(OP_LOAD, 2'd1, 16'h0200, 4'd0);
        cmd(OP_STREAM, 2'd1, 16'd5, 4'd1);
        stream_ready = 1'b1;
        @(negedge clk);
        stream_check("abort_beat1", 1'b1, 16'h0201, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        stream_check("abort_now", 1'b0, 16'h0000, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) rd_check("abort_ch", 2'(i), 16'h0, 1'b0);
        repeat (2) @(negedge clk);
        stream_check("abort_hold", 1'b0, 16'h0000, 1'b0, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        stream_check("abort_after", 1'b0, 16'h0000, 1'b0, 1'b1);
        stream_ready = 1'b0;

        // Bounds back at reset values on ch0: 0xFFFF + 1 wraps to 0
        cmd(OP_LOAD, 2'd0, 16'hFFFF, 4'd0);
        cmd(OP_INC, 2'd0, 16'h0, 4'd1);
        rd_check("rst_bounds", 2'd0, 16'h0000, 1'b1);

        // STREAM N=0 produces no beat
        cmd(OP_STREAM, 2'd0, 16'd0, 4'd1);
        stream_check("n0_a", 1'b0, 16'h0000, 1'b0, 1'b1);
        @(negedge clk);
        stream_check("n0_b", 1'b0, 16'h0000, 1'b0, 1'b1);
        rd_check("n0_ptr", 2'd0, 16'h0000, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pointer_bank.md
POINTER_BANK -- requirements
Module: pointer_bank

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, pointer/base/limit/data width.
REQ-002 SHALL provide parameter NUM_PTR, default 4, number of pointer channels (power of two, >=2).
REQ-003 SHALL provide parameter STEP_W, default 4, width of the step operand.
REQ-004 SHALL provide ports: clk  in  1  clock; reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL provide ports: cmd_valid in 1 command strobe; cmd_ready out 1 command accept; cmd_op in 3 opcode; cmd_sel in $clog2(NUM_PTR) target channel; cmd_data in WIDTH load value/beat count; cmd_step in STEP_W step size.
REQ-006 SHALL provide ports: rd_sel in $clog2(NUM_PTR) read select; rd_ptr out WIDTH pointer value; rd_wrap out 1 sticky wrap flag of rd_sel.
REQ-007 SHALL provide ports: stream_valid out 1; stream_ready in 1; stream_addr out WIDTH; stream_last out 1.

Function
REQ-008 SHALL accept a command on a rising clk edge when cmd_valid && cmd_ready; the effect is visible on rd_ptr/rd_wrap the following cycle.
REQ-009 SHALL decode opcodes: 0 NOP, 1 LOAD (ptr<=cmd_data), 2 INC (ptr+=step), 3 DEC (ptr-=step), 4 SET_BASE, 5 SET_LIMIT, 6 CLR_WRAP, 7 STREAM; LOAD/SET_BASE/SET_LIMIT do not touch wrap flag.
REQ-010 SHALL compute rd_ptr/rd_wrap combinationally from registered state indexed by rd_sel.
REQ-011 SHALL perform INC in WIDTH+1 bits: if ptr+step > limit, result = base + (ptr+step-limit-1) and wrap flag of that channel set; else ptr+step.
REQ-012 SHALL perform DEC: if ptr-step < base (borrow-aware), result = limit - (base-(ptr-step)) + 1 and wrap flag set; else ptr-step.
REQ-013 SHALL, when step > limit-base+1, or base > limit, or ptr outside [base,limit] before INC/DEC, load base and set wrap flag.
REQ-014 SHALL treat step 0 as no change with no wrap.
REQ-015 SHALL run a two-state FSM IDLE/RUN; STREAM with cmd_data=N>0 enters RUN on target cmd_sel with N beats; N=0 completes in IDLE with no beat.
REQ-016 SHALL in RUN drive stream_valid=1, stream_addr=current pointer of streamed channel, stream_last=1 when remaining count is 1.
REQ-017 SHALL on each stream_valid && stream_ready advance the streamed pointer by the latched step using REQ-011 rules and decrement remaining count.
REQ-018 SHALL return to IDLE after the last-beat handshake; stream_valid is 0 the next cycle.
REQ-019 SHALL hold stream_addr and stream_last stable while stream_valid && !stream_ready.
REQ-020 SHALL drive cmd_ready=0 in RUN and 1 in IDLE; no command is accepted in RUN.
REQ-021 SHALL apply CLR_WRAP issued in the same cycle a wrap is generated on another channel independently; same channel: set wins.

Reset
REQ-022 SHALL on reset set all pointers 0, bases 0, limits all-ones, wrap flags 0, FSM IDLE, remaining count 0.
REQ-023 SHALL during and after reset drive cmd_ready=1, stream_valid=0, stream_last=0, stream_addr=0.
REQ-024 SHALL abort an active stream immediately on reset assertion mid-RUN; no further beats issued.

Structure
REQ-025 SHALL place opcode enum and parameter defaults in shared package pointer_bank_pkg.
REQ-026 SHALL implement step-with-wrap arithmetic in one combinational sub-module ptr_wrap_arith, shared by command and stream paths.
REQ-027 SHALL store per-channel state in arrays indexed by channel; no per-channel copies of the arithmetic.

Verification
REQ-028 SHALL cover: reset, LOAD ch1 0x1234 -> rd_sel=1 shows 0x1234 next cycle, others 0, limits 0xFFFF.
REQ-029 SHALL cover: base 0x10, limit 0x1F, ptr 0x1E, INC step 3 -> ptr 0x11, rd_wrap 1; CLR_WRAP -> 0.
REQ-030 SHALL cover: same bounds, ptr 0x11, DEC step 4 -> ptr 0x1D, wrap 1; step 0 -> unchanged.
REQ-031 SHALL cover: ch2 ptr 0x100, STREAM N=3 step 2, stream_ready toggled -> addrs 0x100,0x102,0x104, last on third, cmd_ready 0 throughout, ptr 0x106 after.
REQ-032 SHALL cover: reset asserted after first beat of N=5 stream -> stream_valid 0 immediately, cmd_ready 1, all state at reset values.
REQ-033 SHALL cover: STREAM N=0 -> no stream_valid, cmd_ready stays 1.
